// File: rtl/alu_seq_divider.sv
// Iterative restoring divider: N_W-bit dividend / D_W-bit divisor, one quotient bit per clock.
// Optional early-exit for divisor==0 or dividend<divisor via `DIV_FAST_BYPASS_EN.
module alu_seq_divider #(
  parameter int N_W = 8,
  parameter int D_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_by_zero
);

  localparam int CW = (N_W > 1) ? $clog2(N_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state, state_next;
  logic [N_W-1:0] dvd;
  logic [D_W-1:0] dsr;
  logic [D_W-1:0] rem;
  logic [CW-1:0]  count;
  logic           accept;
  logic           fast;
  logic [D_W:0]   rem_shift;
  logic           fits;
  logic [D_W-1:0] rem_next;
  logic [N_W-1:0] dvd_next;

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef DIV_FAST_BYPASS_EN
  assign fast = (divisor == '0) || (N_W'(divisor) > dividend);
`else
  assign fast = 1'b0;
`endif

  // A restored remainder is always below the divisor, so only the shifted
  // trial value needs the extra bit; quotient bits shift into the vacated LSBs.
  assign rem_shift = {rem, dvd[N_W-1]};
  assign fits      = (rem_shift >= {1'b0, dsr});
  assign rem_next  = fits ? D_W'(rem_shift - {1'b0, dsr}) : rem_shift[D_W-1:0];
  assign dvd_next  = {dvd[N_W-2:0], fits};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state == S_RUN);
    done       = (state == S_DONE);
    case (state)
      S_IDLE:  if (start) state_next = fast ? S_DONE : S_RUN;
      S_RUN:   if (count == '0) state_next = S_DONE;
      S_DONE:  begin
        if (start) state_next = fast ? S_DONE : S_RUN;
        else       state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd         <= dividend;
      dsr         <= divisor;
      rem         <= '0;
      count       <= CW'(N_W - 1);
      div_by_zero <= 1'b0;
`ifdef DIV_FAST_BYPASS_EN
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= '0;
        div_by_zero <= 1'b1;
      end else if (fast) begin
        quotient  <= '0;
        remainder <= dividend[D_W-1:0];
      end
`endif
    end else if (state == S_RUN) begin
      dvd   <= dvd_next;
      rem   <= rem_next;
      count <= count - 1'b1;
      if (count == '0) begin
        if (dsr == '0) begin
          quotient    <= '1;
          remainder   <= '0;
          div_by_zero <= 1'b1;
        end else begin
          quotient  <= dvd_next;
          remainder <= rem_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Scoreboard bench for alu_seq_divider: results checked on every done pulse,
// latency/handshake checked inline by each scenario task.
module tb_alu_seq_divider;

`ifdef DIV_FAST_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;
  exp_t sb[$];

  alu_seq_divider #(.N_W(8), .D_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done: got done=1 q=%0d r=%0d, expected no result pending",
                 quotient, remainder);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
          failures++;
          $display("FAIL sb_result: got q=%0d r=%0d dz=%b, expected q=%0d r=%0d dz=%b",
                   quotient, remainder, div_by_zero, e.q, e.r, e.dz);
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 8'hFF; e.r = 4'd0; e.dz = 1'b1;
    end else begin
      e.q = a / {4'd0, b}; e.r = 4'(a % {4'd0, b}); e.dz = 1'b0;
    end
    sb.push_back(e);
  endtask

  function automatic int exp_lat(input logic [7:0] a, input logic [3:0] b);
    return (BYPASS && (b == 4'd0 || a < {4'd0, b})) ? 1 : 9;
  endfunction

  // Issues one request at the current negedge; returns cycles to done (-1 on timeout).
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         output int lat, output int busy_cycles);
    bit seen = 0;
    start = 1'b1; dividend = a; divisor = b;
    push_exp(a, b);
    lat = -1; busy_cycles = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin seen = 1; lat = i; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, expected 0", done); end
    checks++; if (quotient !== 8'd0) begin failures++; $display("FAIL reset_q: got %0d, expected 0", quotient); end
    checks++; if (remainder !== 4'd0) begin failures++; $display("FAIL reset_r: got %0d, expected 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dz: got %b, expected 0", div_by_zero); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divide;
    int lat, bc;
    run_div(8'd200, 4'd7, lat, bc);
    checks++; if (lat !== 9) begin failures++; $display("FAIL div_latency: got %0d, expected 9", lat); end
    checks++; if (bc !== 8) begin failures++; $display("FAIL div_busy_cycles: got %0d, expected 8", bc); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle: got %b, expected 0", done); end
    checks++; if (quotient !== 8'd28) begin failures++; $display("FAIL q_held: got %0d, expected 28", quotient); end
  endtask

  task automatic test_edges;
    logic [7:0] as [5] = '{8'd255, 8'd255, 8'd0, 8'd9, 8'd15};
    logic [3:0] bs [5] = '{4'd1, 4'd15, 4'd5, 4'd15, 4'd15};
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      run_div(as[i], bs[i], lat, bc);
      checks++;
      if (lat !== exp_lat(as[i], bs[i])) begin
        failures++;
        $display("FAIL edge_latency %0d/%0d: got %0d, expected %0d", as[i], bs[i], lat, exp_lat(as[i], bs[i]));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero;
    int lat, bc;
    run_div(8'd15, 4'd0, lat, bc);
    checks++; if (lat !== exp_lat(8'd15, 4'd0)) begin failures++; $display("FAIL dz_latency: got %0d, expected %0d", lat, exp_lat(8'd15, 4'd0)); end
    @(negedge clk);
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_held: got %b, expected 1", div_by_zero); end
    run_div(8'd30, 4'd4, lat, bc);
    checks++; if (lat !== 9) begin failures++; $display("FAIL after_dz_latency: got %0d, expected 9", lat); end
  endtask

  task automatic test_back_to_back;
    int lat = -1, bc;
    bit seen = 0;
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    push_exp(8'd100, 4'd3);
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 3) begin start = 1'b1; dividend = 8'd50; divisor = 4'd5; end
      if (i == 4) start = 1'b0;
      if (done) begin seen = 1; lat = i; end
    end
    checks++; if (lat !== 9) begin failures++; $display("FAIL ignore_latency: got %0d, expected 9", lat); end
    run_div(8'd50, 4'd5, lat, bc);
    checks++; if (lat !== 9) begin failures++; $display("FAIL b2b_latency: got %0d, expected 9", lat); end
  endtask

  task automatic test_reset_abort;
    int stray = 0;
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_flags: got busy=%b done=%b, expected 0 0", busy, done); end
    checks++; if (quotient !== 8'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      failures++; $display("FAIL abort_outputs: got q=%0d r=%0d dz=%b, expected 0 0 0", quotient, remainder, div_by_zero);
    end
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) stray++;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL abort_no_done: got %0d done pulses, expected 0", stray); end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [7:0] a;
    logic [3:0] b;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      run_div(a, b, lat, bc);
      checks++;
      if (lat !== exp_lat(a, b)) begin
        failures++; $display("FAIL rand_latency %0d/%0d: got %0d, expected %0d", a, b, lat, exp_lat(a, b));
      end
      if (i % 3 == 0) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_divide;
    test_edges;
    test_div_zero;
    test_back_to_back;
    test_reset_abort;
    test_random;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      failures++; $display("FAIL sb_drain: got %0d pending results, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
